// File: rtl/iter_comparator_pkg.sv
// Shared types for the iterative comparator: operation modes, FSM states
// and the mode-class masks used to decode signed and min/max operations.
package cmp_pkg;

  typedef enum logic [2:0] {
    MODE_EQ  = 3'd0,
    MODE_NE  = 3'd1,
    MODE_LT  = 3'd2,
    MODE_LTU = 3'd3,
    MODE_GE  = 3'd4,
    MODE_GEU = 3'd5,
    MODE_MIN = 3'd6,
    MODE_MAX = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One bit per mode_e value: LT, GE, MIN, MAX compare two's complement.
  localparam logic [7:0] SIGNED_MODES = 8'b1101_0100;
  localparam logic [7:0] MINMAX_MODES = 8'b1100_0000;

  function automatic logic is_signed_mode(input mode_e m);
    return SIGNED_MODES[m];
  endfunction

  function automatic logic is_minmax_mode(input mode_e m);
    return MINMAX_MODES[m];
  endfunction

endpackage

// File: rtl/iter_comparator_if.sv
// Request/response bundle of the iterative comparator: operands and mode in,
// busy/done status and the registered result out.
interface iter_comparator_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       mode;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, a, b, mode, input busy, done, result);
  modport slave  (input start, a, b, mode, output busy, done, result);
endinterface

// File: rtl/iter_comparator_chunk_cmp.sv
// Single-slice magnitude compare. i_signed_msb flips both top bits so that
// two's-complement ordering maps onto plain unsigned ordering.
module chunk_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_signed_msb,
  output logic             o_lt,
  output logic             o_gt
);
  localparam logic [CHUNK-1:0] MSB_MASK = {1'b1, {(CHUNK-1){1'b0}}};

  logic [CHUNK-1:0] w_flip;
  logic [CHUNK-1:0] w_a;
  logic [CHUNK-1:0] w_b;

  assign w_flip = i_signed_msb ? MSB_MASK : '0;
  assign w_a    = i_a ^ w_flip;
  assign w_b    = i_b ^ w_flip;
  assign o_lt   = (w_a < w_b);
  assign o_gt   = (w_a > w_b);
endmodule

// File: rtl/iter_comparator.sv
// Iterative WIDTH-bit comparator, one CHUNK slice per cycle MSB first; done pulses N+1 edges after accept.
// Define ITER_COMPARATOR_EARLY_EXIT_EN to finish on the edge after the first differing slice.
module iter_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  iter_comparator_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(N + 1);

  state_e           r_state;
  state_e           w_next;
  mode_e            r_mode;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_result;
  logic [CW-1:0]    r_cnt;
  logic             r_lt;
  logic             r_gt;
  logic             w_slice_lt;
  logic             w_slice_gt;
  logic             w_signed_msb;
  logic             w_accept;
  logic             w_finish;
  logic             w_bit;

  // r_sa/r_sb shift left each slice so the slice under test is always on top.
  assign w_signed_msb = is_signed_mode(r_mode) && (r_cnt == '0);

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .i_a          (r_sa[WIDTH-1 -: CHUNK]),
    .i_b          (r_sb[WIDTH-1 -: CHUNK]),
    .i_signed_msb (w_signed_msb),
    .o_lt         (w_slice_lt),
    .o_gt         (w_slice_gt)
  );

  assign w_accept = bus.start && (r_state != ST_RUN);

`ifdef ITER_COMPARATOR_EARLY_EXIT_EN
  assign w_finish = (r_cnt == CW'(N)) || r_lt || r_gt;
`else
  assign w_finish = (r_cnt == CW'(N));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_next = ST_RUN;
      ST_RUN:  if (w_finish) w_next = ST_DONE;
      ST_DONE: w_next = bus.start ? ST_RUN : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode   <= MODE_EQ;
      r_a      <= '0;
      r_b      <= '0;
      r_sa     <= '0;
      r_sb     <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_lt     <= 1'b0;
      r_gt     <= 1'b0;
    end else if (w_accept) begin
      r_mode <= mode_e'(bus.mode);
      r_a    <= bus.a;
      r_b    <= bus.b;
      r_sa   <= bus.a;
      r_sb   <= bus.b;
      r_cnt  <= '0;
      r_lt   <= 1'b0;
      r_gt   <= 1'b0;
    end else if (r_state == ST_RUN) begin
      if (w_finish) begin
        r_result <= w_result;
      end else begin
        // Only the most significant differing slice decides the order.
        if (!r_lt && !r_gt) begin
          r_lt <= w_slice_lt;
          r_gt <= w_slice_gt;
        end
        r_sa  <= r_sa << CHUNK;
        r_sb  <= r_sb << CHUNK;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    w_bit = 1'b0;
    case (r_mode)
      MODE_EQ:           w_bit = ~r_lt & ~r_gt;
      MODE_NE:           w_bit = r_lt | r_gt;
      MODE_LT, MODE_LTU: w_bit = r_lt;
      MODE_GE, MODE_GEU: w_bit = ~r_lt;
      MODE_MIN:          w_bit = r_lt;
      MODE_MAX:          w_bit = r_gt;
      default:           w_bit = 1'b0;
    endcase
    w_result = is_minmax_mode(r_mode) ? (w_bit ? r_a : r_b) : {{(WIDTH-1){1'b0}}, w_bit};
  end

  assign bus.busy   = (r_state == ST_RUN);
  assign bus.done   = (r_state == ST_DONE);
  assign bus.result = r_result;
endmodule

// File: tb/tb_iter_comparator.sv
// Scoreboard bench for iter_comparator (WIDTH=32, CHUNK=8): directed corner cases,
// a mid-RUN reset, then randomised traffic against an arithmetic reference model.
module tb_iter_comparator;
  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int N     = WIDTH / CHUNK;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          hold_err = 0;
  int          busy_err = 0;
  logic [31:0] last_res = '0;
  exp_t        q[$];

  iter_comparator_if #(.WIDTH(WIDTH)) bus ();

  iter_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m);
    logic slt, sgt;
    slt = $signed(a) < $signed(b);
    sgt = $signed(a) > $signed(b);
    case (m)
      3'd0:    return {31'd0, a == b};
      3'd1:    return {31'd0, a != b};
      3'd2:    return {31'd0, slt};
      3'd3:    return {31'd0, a < b};
      3'd4:    return {31'd0, !slt};
      3'd5:    return {31'd0, a >= b};
      3'd6:    return slt ? a : b;
      default: return sgt ? a : b;
    endcase
  endfunction

  // Edges from acceptance to done: fixed, or first differing byte (1-based) + 1.
  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
    int k;
    k = N + 1;
    for (int i = 0; i < N; i++)
      if (k == N + 1 && a[(N-1-i)*CHUNK +: CHUNK] != b[(N-1-i)*CHUNK +: CHUNK]) k = i + 2;
`ifdef ITER_COMPARATOR_EARLY_EXIT_EN
    return k;
`else
    return (k > 0) ? N + 1 : 0;
`endif
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_res = '0;
      hold_err = 0;
      busy_err = 0;
    end else if (bus.done) begin
      if (bus.busy) busy_err++;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done: done with nothing outstanding, result %0h", bus.result);
      end else begin
        e = q.pop_front();
        check("result", bus.result, e.res);
        check("latency", 32'(cyc - e.acc), 32'(e.lat));
        check("busy_in_run", 32'(busy_err), 32'd0);
        check("result_hold", 32'(hold_err), 32'd0);
      end
      busy_err = 0;
      hold_err = 0;
      last_res = bus.result;
    end else begin
      if (bus.result !== last_res) hold_err++;
      if (q.size() != 0 && !bus.busy) busy_err++;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 50);
    if (bus.busy) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles, expected 0", bus.busy, n);
      $fatal(1, "comparator stuck busy");
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m,
                       input int gap, input bit mid);
    exp_t e;
    wait_idle();
    repeat (gap) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.mode  = m;
    @(posedge clk);
    #1;
    e.res = ref_res(a, b, m);
    e.lat = ref_lat(a, b);
    e.acc = cyc;
    q.push_back(e);
    // Scramble inputs after acceptance; the operation must not notice.
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.mode  = 3'($urandom);
    if (mid) begin
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  task automatic reset_mid_run();
    wait_idle();
    bus.start = 1'b1;
    bus.a     = 32'h0;
    bus.b     = 32'h1;
    bus.mode  = 3'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.mode  = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", bus.result, 32'd0);
    rst = 1'b0;

    do_op(32'h0, 32'h1, 3'd3, 1, 1'b0);
    do_op(32'h1, 32'h1, 3'd0, 0, 1'b0);
    do_op(32'h1, 32'h1, 3'd2, 0, 1'b0);
    do_op(32'h1, 32'h1, 3'd4, 0, 1'b0);
    do_op(32'h1, 32'h1, 3'd1, 0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'h1, 3'd2, 0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'h1, 3'd3, 0, 1'b0);
    do_op(32'h8000_0000, 32'h7FFF_FFFF, 3'd6, 0, 1'b0);
    do_op(32'h8000_0000, 32'h7FFF_FFFF, 3'd7, 0, 1'b0);
    do_op(32'h0100_0000, 32'h0, 3'd5, 2, 1'b0);
    do_op(32'h5, 32'h5, 3'd0, 0, 1'b0);
    do_op(32'h1234_5678, 32'h1234_5600, 3'd7, 0, 1'b1);
    do_op(32'hCAFE_0000, 32'h0000_BEEF, 3'd6, 0, 1'b1);

    reset_mid_run();
    do_op(32'h2, 32'h1, 3'd5, 1, 1'b0);

    for (int i = 0; i < 80; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = ra;
        2:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
        default: rb = ra ^ 32'h8000_0000;
      endcase
      do_op(ra, rb, 3'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
            $urandom_range(0, 3) == 0);
    end

    begin
      int n;
      n = 0;
      while (q.size() != 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
    end
    check("drain", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
